// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the dot-product array, the partial-sum accumulator and its consumer.
// The DUT connects through the slave modport and the producer/consumer side through master.
interface psum_accumulator_if #(
    parameter int OUT_SIZE = 20,
    parameter int ACC_SIZE = 32,
    parameter int CNT_SIZE = 8
);
    logic signed [OUT_SIZE-1:0] sum_i;
    logic signed [OUT_SIZE-1:0] carry_i;
    logic                       last_i;
    logic                       valid_i;
    logic                       ready_o;
    logic signed [ACC_SIZE-1:0] acc_o;
    logic [CNT_SIZE-1:0]        cnt_o;
    logic                       ovf_o;
    logic                       valid_o;
    logic                       ready_i;

    modport master (
        output sum_i, carry_i, last_i, valid_i, ready_i,
        input  ready_o, acc_o, cnt_o, ovf_o, valid_o
    );

    modport slave (
        input  sum_i, carry_i, last_i, valid_i, ready_i,
        output ready_o, acc_o, cnt_o, ovf_o, valid_o
    );
endinterface

// File: rtl/psum_accumulator.sv
// Resolves the array's (sum, carry) pairs and accumulates them per group into a signed result.
// Build option SATURATE_EN: clamp every fold to the signed ACC_SIZE range instead of wrapping.
module psum_accumulator #(
    parameter int OUT_SIZE = 20,
    parameter int ACC_SIZE = 32,
    parameter int CNT_SIZE = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    psum_accumulator_if.slave bus
);
    localparam int RES_W  = OUT_SIZE + 1;
    localparam int WIDE_W = ACC_SIZE + 1;

    if (ACC_SIZE < OUT_SIZE + 1) begin : g_width_check
        $error("psum_accumulator: ACC_SIZE must be at least OUT_SIZE+1");
    end

    // One extra bit makes the carry-propagate add of two OUT_SIZE words overflow-free.
    function automatic logic signed [ACC_SIZE-1:0] resolve(
        input logic signed [OUT_SIZE-1:0] s,
        input logic signed [OUT_SIZE-1:0] c
    );
        logic signed [RES_W-1:0] r;
        r = RES_W'(s) + RES_W'(c);
        return ACC_SIZE'(r);
    endfunction

`ifdef SATURATE_EN
    function automatic logic signed [ACC_SIZE-1:0] sat_clamp(input logic signed [ACC_SIZE:0] wide);
        if (wide[ACC_SIZE] == wide[ACC_SIZE-1]) return wide[ACC_SIZE-1:0];
        else if (wide[ACC_SIZE])                return {1'b1, {(ACC_SIZE-1){1'b0}}};
        else                                    return {1'b0, {(ACC_SIZE-1){1'b1}}};
    endfunction
`endif

    logic                       vld_p1;
    logic                       last_p1;
    logic signed [ACC_SIZE-1:0] psum_p1;

    logic signed [ACC_SIZE-1:0] acc_run_p2;
    logic [CNT_SIZE-1:0]        cnt_run_p2;
    logic                       ovf_run_p2;
    logic signed [ACC_SIZE-1:0] acc_p2;
    logic [CNT_SIZE-1:0]        cnt_p2;
    logic                       ovf_p2;
    logic                       vld_p2;

    logic                       adv_p1;
    logic                       ready_p0;
    logic signed [ACC_SIZE:0]   fold_wide;
    logic signed [ACC_SIZE-1:0] fold_val;
    logic                       fold_ovf;
    logic [CNT_SIZE-1:0]        cnt_next;

    // A last beat may only fold when the result register is free or draining this edge.
    assign adv_p1   = vld_p1 && !(last_p1 && vld_p2 && !bus.ready_i);
    assign ready_p0 = !vld_p1 || adv_p1;

    always_comb begin
        fold_wide = WIDE_W'(acc_run_p2) + WIDE_W'(psum_p1);
        fold_ovf  = fold_wide[ACC_SIZE] ^ fold_wide[ACC_SIZE-1];
`ifdef SATURATE_EN
        fold_val  = sat_clamp(fold_wide);
`else
        fold_val  = fold_wide[ACC_SIZE-1:0];
`endif
        cnt_next  = (&cnt_run_p2) ? cnt_run_p2 : cnt_run_p2 + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            psum_p1    <= '0;
            acc_run_p2 <= '0;
            cnt_run_p2 <= '0;
            ovf_run_p2 <= 1'b0;
            acc_p2     <= '0;
            cnt_p2     <= '0;
            ovf_p2     <= 1'b0;
            vld_p2     <= 1'b0;
        end else begin
            // ---- S1: capture a resolved beat ----
            if (ready_p0) begin
                vld_p1 <= bus.valid_i;
                if (bus.valid_i) begin
                    psum_p1 <= resolve(bus.sum_i, bus.carry_i);
                    last_p1 <= bus.last_i;
                end
            end

            // ---- S2: fold into the running sum or close the group ----
            if (vld_p2 && bus.ready_i)
                vld_p2 <= 1'b0;

            if (adv_p1) begin
                if (last_p1) begin
                    acc_p2     <= fold_val;
                    cnt_p2     <= cnt_next;
                    ovf_p2     <= ovf_run_p2 | fold_ovf;
                    vld_p2     <= 1'b1;
                    acc_run_p2 <= '0;
                    cnt_run_p2 <= '0;
                    ovf_run_p2 <= 1'b0;
                end else begin
                    acc_run_p2 <= fold_val;
                    cnt_run_p2 <= cnt_next;
                    ovf_run_p2 <= ovf_run_p2 | fold_ovf;
                end
            end
        end
    end

    assign bus.ready_o = ready_p0;
    assign bus.acc_o   = acc_p2;
    assign bus.cnt_o   = cnt_p2;
    assign bus.ovf_o   = ovf_p2;
    assign bus.valid_o = vld_p2;
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus a randomized run against a group-level model.
// A second instance with ACC_SIZE=21 covers accumulator overflow.
module tb_psum_accumulator;
    localparam int OUT = 20;
    localparam int ACC = 32;
    localparam int CNT = 8;
    localparam int CNT_MAX = (1 << CNT) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    psum_accumulator_if #(.OUT_SIZE(OUT), .ACC_SIZE(ACC), .CNT_SIZE(CNT)) bus ();
    psum_accumulator_if #(.OUT_SIZE(OUT), .ACC_SIZE(21),  .CNT_SIZE(CNT)) bus21 ();

    psum_accumulator #(.OUT_SIZE(OUT), .ACC_SIZE(ACC), .CNT_SIZE(CNT)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );
    psum_accumulator #(.OUT_SIZE(OUT), .ACC_SIZE(21), .CNT_SIZE(CNT)) dut21 (
        .clk_i(clk), .rst_i(rst), .bus(bus21)
    );

    typedef struct { longint acc; int cnt; bit ovf; } res_t;
    res_t exp_q[$];
    res_t obs_q[$];
    longint m_acc;
    int     m_cnt;
    bit     m_ovf;
    int     n_cmp = 0;
    int     n_err = 0;

    // Exact-integer fold of one beat into a w-bit signed accumulator.
    function automatic longint model_add(input longint a, input longint v, input int w, output bit o);
        longint mx, mn, s;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s  = a + v;
        o  = (s > mx) || (s < mn);
`ifdef SATURATE_EN
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
`else
        if (s > mx) s -= (longint'(1) <<< w);
        else if (s < mn) s += (longint'(1) <<< w);
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        res_t   r;
        longint v;
        bit     o;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0;
        end else begin
            if (bus.valid_o && bus.ready_i) begin
                r.acc = longint'(bus.acc_o); r.cnt = int'(bus.cnt_o); r.ovf = bus.ovf_o;
                obs_q.push_back(r);
            end
            if (bus.valid_i && bus.ready_o) begin
                v = longint'(bus.sum_i) + longint'(bus.carry_i);
                m_acc = model_add(m_acc, v, ACC, o);
                m_ovf = m_ovf | o;
                m_cnt++;
                if (bus.last_i) begin
                    r.acc = m_acc; r.cnt = (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt; r.ovf = m_ovf;
                    exp_q.push_back(r);
                    m_acc = 0; m_cnt = 0; m_ovf = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.sum_i = '0; bus.carry_i = '0;
        bus21.valid_i = 1'b0; bus21.last_i = 1'b0; bus21.sum_i = '0; bus21.carry_i = '0;
    endtask

    task automatic beat(input int s, input int c, input bit l);
        bus.sum_i = OUT'(s); bus.carry_i = OUT'(c); bus.last_i = l; bus.valid_i = 1'b1;
    endtask

    task automatic do_reset;
        idle();
        bus.ready_i = 1'b1; bus21.ready_i = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [41:0] got;
        idle();
        bus.ready_i = 1'b0; bus21.ready_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== 42'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", got);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o);
        end
    endtask

    task automatic test_single_beat;
        logic [41:0] got;
        do_reset();
        beat(5, -3, 1'b1);
        tick();
        idle();
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_err++; $display("FAIL single_latency: valid_o got %b expected 0", bus.valid_o);
        end
        tick();
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 32'sd2, 8'd1, 1'b0}) begin
            n_err++; $display("FAIL single_result: got %h expected %h", got, {1'b1, 32'sd2, 8'd1, 1'b0});
        end
        tick();
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_err++; $display("FAIL single_drain: valid_o got %b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_back_to_back;
        int vals[4] = '{100, -40, 7, 1};
        logic [41:0] got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            beat(vals[i] + 3, -3, i == 3);
            n_cmp++;
            if (bus.ready_o !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.ready_o);
            end
            tick();
        end
        beat(50, 0, 1'b0);
        n_cmp++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_no_bubble: ready_o got %b expected 1", bus.ready_o);
        end
        tick();
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 32'sd68, 8'd4, 1'b0}) begin
            n_err++; $display("FAIL b2b_group1: got %h expected %h", got, {1'b1, 32'sd68, 8'd4, 1'b0});
        end
        beat(2, 0, 1'b1);
        tick();
        idle();
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_handshake: valid_o got %b expected 0", bus.valid_o);
        end
        tick();
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 32'sd52, 8'd2, 1'b0}) begin
            n_err++; $display("FAIL b2b_group2: got %h expected %h", got, {1'b1, 32'sd52, 8'd2, 1'b0});
        end
    endtask

    task automatic test_backpressure;
        logic [41:0] got;
        do_reset();
        bus.ready_i = 1'b0;
        beat(10, 0, 1'b1);
        tick();
        beat(3, 0, 1'b0);
        tick();
        beat(4, 0, 1'b1);
        n_cmp++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_nonlast_flows: ready_o got %b expected 1", bus.ready_o);
        end
        tick();
        beat(77, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
            n_cmp++;
            if (bus.ready_o !== 1'b0 || got !== {1'b1, 32'sd10, 8'd1, 1'b0}) begin
                n_err++; $display("FAIL bp_stall_%0d: ready_o %b out %h, need ready_o 0 out %h",
                                  k, bus.ready_o, got, {1'b1, 32'sd10, 8'd1, 1'b0});
            end
            tick();
        end
        bus.ready_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        idle();
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 32'sd7, 8'd2, 1'b0}) begin
            n_err++; $display("FAIL bp_second_result: got %h expected %h", got, {1'b1, 32'sd7, 8'd2, 1'b0});
        end
    endtask

    task automatic test_overflow21;
        logic signed [20:0] exp21;
        logic [30:0] got;
`ifdef SATURATE_EN
        exp21 = 21'sh0FFFFF;
`else
        exp21 = 21'sh100000;
`endif
        do_reset();
        bus21.sum_i = 20'sd262144; bus21.carry_i = 20'sd262144; bus21.last_i = 1'b0; bus21.valid_i = 1'b1;
        tick();
        bus21.last_i = 1'b1;
        tick();
        idle();
        tick();
        got = {bus21.valid_o, bus21.acc_o, bus21.cnt_o, bus21.ovf_o};
        n_cmp++;
        if (got !== {1'b1, exp21, 8'd2, 1'b1}) begin
            n_err++; $display("FAIL ovf21_result: got %h expected %h", got, {1'b1, exp21, 8'd2, 1'b1});
        end
        bus21.sum_i = 20'sd1; bus21.carry_i = 20'sd0; bus21.last_i = 1'b1; bus21.valid_i = 1'b1;
        tick();
        idle();
        tick();
        got = {bus21.valid_o, bus21.acc_o, bus21.cnt_o, bus21.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 21'sd1, 8'd1, 1'b0}) begin
            n_err++; $display("FAIL ovf21_clean_next: got %h expected %h", got, {1'b1, 21'sd1, 8'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid;
        logic [41:0] got;
        do_reset();
        beat(20, 0, 1'b1);
        tick();
        bus.ready_i = 1'b0;
        beat(11, 0, 1'b0); tick();
        beat(22, 0, 1'b0); tick();
        beat(33, 0, 1'b0); tick();
        idle();
        #2 rst = 1'b1;
        #1;
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== 42'd0) begin
            n_err++; $display("FAIL rstmid_async_clear: got %h expected 0", got);
        end
        #1 rst = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        beat(4, 5, 1'b1);
        tick();
        idle();
        tick();
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 32'sd9, 8'd1, 1'b0}) begin
            n_err++; $display("FAIL rstmid_fresh_group: got %h expected %h", got, {1'b1, 32'sd9, 8'd1, 1'b0});
        end
    endtask

    task automatic test_cnt_saturation;
        logic [41:0] got;
        bit ready_ok = 1'b1;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            beat(-1, 2, i == 299);
            if (bus.ready_o !== 1'b1) ready_ok = 1'b0;
            tick();
        end
        idle();
        n_cmp++;
        if (ready_ok !== 1'b1) begin
            n_err++; $display("FAIL cnt_stream_ready: got %b expected 1", ready_ok);
        end
        tick();
        got = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
        n_cmp++;
        if (got !== {1'b1, 32'sd300, 8'd255, 1'b0}) begin
            n_err++; $display("FAIL cnt_saturate: got %h expected %h", got, {1'b1, 32'sd300, 8'd255, 1'b0});
        end
    endtask

    task automatic test_random;
        logic [41:0] held;
        bit stall;
        int nmin;
        do_reset();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 600; i++) begin
            bus.valid_i = ($urandom % 10) < 7;
            bus.last_i  = ($urandom % 4) == 0;
            bus.sum_i   = OUT'($urandom);
            bus.carry_i = OUT'($urandom);
            bus.ready_i = ($urandom % 10) < 6;
            #1;
            stall = bus.valid_o && !bus.ready_i;
            held  = {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o};
            tick();
            if (stall) begin
                n_cmp++;
                if ({bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o} !== held) begin
                    n_err++; $display("FAIL rand_hold_%0d: got %h expected %h", i,
                                      {bus.valid_o, bus.acc_o, bus.cnt_o, bus.ovf_o}, held);
                end
            end
        end
        bus.ready_i = 1'b1;
        beat(1, 0, 1'b1);
        tick();
        idle();
        for (int k = 0; k < 6; k++) tick();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin
            n_err++; $display("FAIL rand_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < nmin; k++) begin
            n_cmp++;
            if (obs_q[k].acc != exp_q[k].acc || obs_q[k].cnt != exp_q[k].cnt || obs_q[k].ovf != exp_q[k].ovf) begin
                n_err++; $display("FAIL rand_result_%0d: got acc %0d cnt %0d ovf %0d expected acc %0d cnt %0d ovf %0d",
                                  k, obs_q[k].acc, obs_q[k].cnt, obs_q[k].ovf,
                                  exp_q[k].acc, exp_q[k].cnt, exp_q[k].ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_overflow21();
        test_reset_mid();
        test_cnt_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
